// File: rtl/down_timer_pkg.sv
// down_timer_pkg: state encoding shared by the down_timer_n timer.
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/down_timer_n.sv
// down_timer_n: loadable down-count timer; one-shot by default, periodic when
// DOWN_TIMER_AUTORELOAD_EN is defined (reloads from the latched start value).
module down_timer_n
    import down_timer_pkg::*;
#(
    parameter int n            = 4,
    parameter int counter_bits = 4
) (
    input  logic                    clk,
    input  logic                    r,
    input  logic                    start,
    input  logic [counter_bits-1:0] len,
    input  logic                    en,
    input  logic                    abort,
    output logic                    busy,
    output logic                    bo,
    output logic                    done,
    output logic [counter_bits-1:0] q
);

    localparam logic [counter_bits-1:0] DEF_LOAD = counter_bits'(n - 1);

    state_t                  state_q, state_d;
    logic [counter_bits-1:0] cnt_q, cnt_d;
    logic [counter_bits-1:0] load_val;
    logic                    start_ok;

    assign load_val = (len == '0) ? DEF_LOAD : len;
    // start is honoured only outside RUN, and never alongside abort
    assign start_ok = start && !abort && (state_q != RUN);

    assign busy = (state_q != IDLE);
    assign bo   = (state_q == RUN) && (cnt_q == '0) && en;
    assign q    = cnt_q;

`ifdef DOWN_TIMER_AUTORELOAD_EN
    logic [counter_bits-1:0] reload_q, reload_d;

    assign done = bo;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start_ok) begin
            state_d  = RUN;
            cnt_d    = load_val;
            reload_d = load_val;
        end else if (state_q == RUN && en) begin
            cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : reload_q;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
        end
    end
`else
    assign done = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start_ok) begin
            state_d = RUN;
            cnt_d   = load_val;
        end else if (state_q == RUN && en) begin
            state_d = (cnt_q != '0) ? RUN : DONE;
            cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_down_timer_n.sv
// tb_down_timer_n: table-driven checks of down_timer_n plus reset corner sequences.
module tb_down_timer_n;

    localparam int N  = 4;
    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          r = 1'b0;
    logic          start = 1'b0;
    logic          en = 1'b0;
    logic          abort = 1'b0;
    logic [CB-1:0] len = '0;
    logic          busy, bo, done;
    logic [CB-1:0] q;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          start;
        logic [CB-1:0] len;
        logic          en;
        logic          abort;
        logic          busy;
        logic          bo;
        logic          done;
        logic [CB-1:0] q;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    down_timer_n #(.n(N), .counter_bits(CB)) dut (
        .clk(clk), .r(r), .start(start), .len(len), .en(en), .abort(abort),
        .busy(busy), .bo(bo), .done(done), .q(q)
    );

    function automatic vec_t mk(int s, int l, int e, int a, int b, int bb, int d, int qq);
        vec_t v;
        v.start = s[0];
        v.len   = CB'(l);
        v.en    = e[0];
        v.abort = a[0];
        v.busy  = b[0];
        v.bo    = bb[0];
        v.done  = d[0];
        v.q     = CB'(qq);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int b, input int bb, input int d, input int qq);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".bo"}, int'(bo), bb);
        chk({tag, ".done"}, int'(done), d);
        chk({tag, ".q"}, int'(q), qq);
    endtask

    initial begin
`ifdef DOWN_TIMER_AUTORELOAD_EN
        tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 5, 1, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
`else
        tbl.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
`endif
        en = 1'b1;
        #2;
        chk_all("reset", 0, 0, 0, 0);
        #5 r = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            start = tbl[i].start;
            len   = tbl[i].len;
            en    = tbl[i].en;
            abort = tbl[i].abort;
            #1;
            chk_all($sformatf("row%0d", i), int'(tbl[i].busy), int'(tbl[i].bo),
                    int'(tbl[i].done), int'(tbl[i].q));
        end

        // reset pulled mid-count must clear state without a clock edge
        @(negedge clk);
        start = 1'b1; len = 4'd6; en = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_rst.q", int'(q), 4);
        #1 r = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        r = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk_all($sformatf("post_rst%0d", k), 0, 0, 0, 0);
        end

        // start captured on the very first edge after release
        @(negedge clk);
        r = 1'b0;
        #2;
        r = 1'b1; start = 1'b1; len = 4'd1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk_all("first_start", 1, 0, 0, 1);
        @(negedge clk);
        #1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
        chk_all("first_end", 1, 1, 1, 0);
        @(negedge clk);
        #1;
        chk_all("first_reload", 1, 0, 0, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk_all("final_abort", 0, 0, 0, 0);
`else
        chk_all("first_end", 1, 1, 0, 0);
        @(negedge clk);
        #1;
        chk_all("first_done", 1, 0, 1, 0);
        @(negedge clk);
        #1;
        chk_all("first_idle", 0, 0, 0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
